// File: rtl/tage_history_reg.sv
// Speculative global/path history for the TAGE front end. Each accepted branch
// checkpoints the history it saw; a mispredicted resolve rebuilds history from that checkpoint.
module tage_history_reg #(
   parameter int GlobLen   = 131,
   parameter int PLen      = 16,
   parameter int pc_len    = 32,
   parameter int PathBit   = 2,
   parameter int CkptDepth = 8,
   localparam int PtrW     = $clog2(CkptDepth),
   localparam int CntW     = PtrW + 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_pred_valid,
   input  logic               i_pred_taken,
   input  logic [pc_len-1:0]  i_pred_pc,
   output logic               o_pred_ready,
   input  logic               i_res_valid,
   input  logic               i_res_mispredict,
   input  logic               i_res_taken,
   output logic [GlobLen-1:0] o_ghist,
   output logic [PLen-1:0]    o_phist,
   output logic               o_index_tag_enable,
   output logic [CntW-1:0]    o_inflight,
   output logic               o_res_error
);

   typedef enum logic {NORMAL = 1'b0, RECOVER = 1'b1} state_t;

   // The oldest bit of each history is shifted out on restore, so it is not stored.
   typedef struct packed {
      logic [GlobLen-2:0] ghist;
      logic [PLen-2:0]    phist;
      logic               pbit;
   } ckpt_t;

   localparam logic [CntW-1:0] FULL = CntW'(CkptDepth);

   state_t             r_state, w_state_nx;
   logic [GlobLen-1:0] r_ghist, w_ghist_nx;
   logic [PLen-1:0]    r_phist, w_phist_nx;
   logic [PtrW-1:0]    r_head, w_head_nx;
   logic [PtrW-1:0]    r_tail, w_tail_nx;
   logic [CntW-1:0]    r_cnt, w_cnt_nx;
   logic               r_ite;
   logic               r_err;
   ckpt_t              r_q [CkptDepth];

   logic  w_full, w_ready;
   logic  w_res_ok, w_res_bad, w_mis, w_push, w_pop, w_pbit, w_hist_chg;
   ckpt_t w_head_ent, w_push_ent;
   logic  w_unused_pc;

   assign w_pbit      = i_pred_pc[PathBit];
   assign w_unused_pc = ^i_pred_pc;
   assign w_head_ent  = r_q[r_head];

   assign w_full  = (r_cnt == FULL);
   assign w_ready = (r_state == NORMAL) && !w_full;

   // A resolve in RECOVER sees an already-flushed queue and is an error like any empty resolve.
   assign w_res_ok  = i_res_valid && (r_state == NORMAL) && (r_cnt != '0);
   assign w_res_bad = i_res_valid && !w_res_ok;
   assign w_mis     = w_res_ok && i_res_mispredict;
   assign w_pop     = w_res_ok;
   // A prediction arriving with a mispredict is on the wrong path and is dropped.
   assign w_push    = i_pred_valid && w_ready && !w_mis;

   assign w_push_ent.ghist = r_ghist[GlobLen-2:0];
   assign w_push_ent.phist = r_phist[PLen-2:0];
   assign w_push_ent.pbit  = w_pbit;

   always_comb begin
      w_ghist_nx = r_ghist;
      w_phist_nx = r_phist;
      w_hist_chg = 1'b0;
      if (w_mis) begin
         w_ghist_nx = {w_head_ent.ghist, i_res_taken};
         w_phist_nx = {w_head_ent.phist, w_head_ent.pbit};
         w_hist_chg = 1'b1;
      end else if (w_push) begin
         w_ghist_nx = {r_ghist[GlobLen-2:0], i_pred_taken};
         w_phist_nx = {r_phist[PLen-2:0], w_pbit};
         w_hist_chg = 1'b1;
      end
   end

   always_comb begin
      w_head_nx = r_head;
      w_tail_nx = r_tail;
      w_cnt_nx  = r_cnt;
      if (w_mis) begin
         w_head_nx = '0;
         w_tail_nx = '0;
         w_cnt_nx  = '0;
      end else begin
         if (w_push) w_tail_nx = r_tail + PtrW'(1);
         if (w_pop)  w_head_nx = r_head + PtrW'(1);
         if (w_push && !w_pop)      w_cnt_nx = r_cnt + CntW'(1);
         else if (!w_push && w_pop) w_cnt_nx = r_cnt - CntW'(1);
      end
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         NORMAL:  if (w_mis) w_state_nx = RECOVER;
         RECOVER: w_state_nx = NORMAL;
         default: w_state_nx = NORMAL;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= NORMAL;
         r_ghist <= '0;
         r_phist <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_cnt   <= '0;
         r_ite   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_ghist <= w_ghist_nx;
         r_phist <= w_phist_nx;
         r_head  <= w_head_nx;
         r_tail  <= w_tail_nx;
         r_cnt   <= w_cnt_nx;
         r_ite   <= w_hist_chg;
         if (w_res_bad) r_err <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_q[r_tail] <= w_push_ent;
   end

   assign o_pred_ready       = w_ready;
   assign o_ghist            = r_ghist;
   assign o_phist            = r_phist;
   assign o_index_tag_enable = r_ite;
   assign o_inflight         = r_cnt;
   assign o_res_error        = r_err;

endmodule
